// File: rtl/debounce_tick.sv
// rtl/debounce_tick.sv - two-flop synchronizer plus tick-sampled debounce FSM with rise/fall pulses
module debounce_tick #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_TICKS);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  logic          sync1_q;
  logic          s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_inc;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Bring the raw input into the clock domain; only s_q is used beyond this point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      s_q     <= sync1_q;
    end
  end

  // The counter never exceeds STABLE_TICKS-1 while waiting, so the increment cannot wrap
  assign count_inc = count_q + CW'(1);

  // Next-state logic: a bounce back always wins over a coincident final tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (s_q) begin
          state_d = S_WAIT_HIGH;
          count_d = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!s_q) begin
          state_d = S_LOW;
          count_d = '0;
        end else if (tick) begin
          if (count_inc == LAST_COUNT) begin
            state_d = S_HIGH;
            count_d = '0;
            rise_d  = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end
      S_HIGH: begin
        if (!s_q) begin
          state_d = S_WAIT_LOW;
          count_d = '0;
        end
      end
      S_WAIT_LOW: begin
        if (s_q) begin
          state_d = S_HIGH;
          count_d = '0;
        end else if (tick) begin
          if (count_inc == LAST_COUNT) begin
            state_d = S_LOW;
            count_d = '0;
            fall_d  = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end
      default: begin
        state_d = S_LOW;
        count_d = '0;
      end
    endcase
    level_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
  end

  // State, counter and registered outputs; pulses self-clear because their _d defaults to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOW;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_debounce_tick.sv
// tb/tb_debounce_tick.sv - scoreboard bench for debounce_tick with STABLE_TICKS=4
module tb_debounce_tick;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic btn_in = 1'b0;
  logic level, rise, fall;

  debounce_tick #(.STABLE_TICKS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .btn_in (btn_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int checks = 0;
  int fails  = 0;

  // expected pulses: kind 1 = rise, 0 = fall, with the edge number that must produce it
  int exp_kind[$];
  int exp_edge[$];

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at edge %0d", name, act, req, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int kind, input int e);
    exp_kind.push_back(kind);
    exp_edge.push_back(e);
  endtask

  // monitor: every pulse must match the head of the scoreboard; an overdue entry is a miss
  always @(negedge clk) begin
    int k, e;
    if (rise && fall) begin
      checks++;
      fails++;
      $display("FAIL both_pulses: rise and fall high together at edge %0d", edge_n);
    end else if (rise || fall) begin
      checks++;
      if (exp_kind.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at edge %0d, none expected", rise, fall, edge_n);
      end else begin
        k = exp_kind.pop_front();
        e = exp_edge.pop_front();
        if (k != (rise ? 1 : 0) || e != edge_n) begin
          fails++;
          $display("FAIL pulse_match: got %s at edge %0d expected %s at edge %0d",
                   rise ? "rise" : "fall", edge_n, k ? "rise" : "fall", e);
        end
      end
    end else if (exp_edge.size() > 0 && exp_edge[0] < edge_n) begin
      checks++;
      fails++;
      k = exp_kind.pop_front();
      e = exp_edge.pop_front();
      $display("FAIL missing_pulse: no %s by edge %0d expected at edge %0d", k ? "rise" : "fall", edge_n, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0; btn_in = 1'b0; tick = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);

    // 1. reset asserted mid-cycle while a debounce is in flight
    btn_in = 1'b1; tick = 1'b1;
    step(4);
    #2 rst = 1'b0;
    #1;
    chk("rst_level_now", level, 1'b0);
    chk("rst_rise_now",  rise,  1'b0);
    chk("rst_fall_now",  fall,  1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_level_hold", level, 1'b0);
      chk("rst_rise_hold",  rise,  1'b0);
      chk("rst_fall_hold",  fall,  1'b0);
    end
    @(posedge clk); #1;
    btn_in = 1'b0; rst = 1'b1;
    step(3);

    // 2. clean press with tick held high: rise on the 7th edge counting the first as 1
    btn_in = 1'b1;
    expect_pulse(1, edge_n + 7);
    step(6);
    chk("press_level_edge6", level, 1'b0);
    step(1);
    chk("press_level_edge7", level, 1'b1);
    chk("press_rise_edge7",  rise,  1'b1);
    step(1);
    chk("press_level_edge8", level, 1'b1);
    chk("press_rise_edge8",  rise,  1'b0);

    // 5b. s returns high exactly when the 4th tick arrives: stays HIGH, no fall
    btn_in = 1'b0;
    step(4);
    btn_in = 1'b1;
    step(6);
    chk("collide_level", level, 1'b1);

    // 5a. release from HIGH: fall after 4 counted ticks
    btn_in = 1'b0;
    expect_pulse(0, edge_n + 7);
    step(6);
    chk("release_level_edge6", level, 1'b1);
    step(1);
    chk("release_level_edge7", level, 1'b0);
    chk("release_fall_edge7",  fall,  1'b1);
    step(1);
    chk("release_fall_edge8",  fall,  1'b0);

    // 3. short pulse and repeated glitches never complete a debounce
    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    step(6);
    chk("bounce_level", level, 1'b0);
    for (int i = 0; i < 20; i++) begin
      btn_in = ~btn_in;
      step(2);
    end
    btn_in = 1'b0;
    step(6);
    chk("glitch_level", level, 1'b0);

    // 4. sparse tick every 16 cycles; the tick on the WAIT_HIGH entry edge is not counted
    k = edge_n;
    btn_in = 1'b1;
    expect_pulse(1, k + 67);
    for (int i = 0; i < 70; i++) begin
      tick = ((i % 16) == 2);
      step(1);
      if (i == 50) chk("sparse_level_3ticks", level, 1'b0);
      if (i == 65) chk("sparse_level_pre",    level, 1'b0);
      if (i == 66) chk("sparse_level_post",   level, 1'b1);
    end

    // back to LOW with tick held high
    tick = 1'b1;
    btn_in = 1'b0;
    expect_pulse(0, edge_n + 7);
    step(10);
    chk("back_low_level", level, 1'b0);

    // 6. reset after two counted ticks in WAIT_HIGH, then a full debounce after release
    btn_in = 1'b1;
    step(5);
    #2 rst = 1'b0;
    #1;
    chk("midwait_rst_level", level, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("midwait_rst_rise", rise, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    expect_pulse(1, edge_n + 7);
    step(6);
    chk("midwait_level_edge6", level, 1'b0);
    step(1);
    chk("midwait_level_edge7", level, 1'b1);
    step(3);

    tick = 1'b0;
    step(5);
    checks++;
    if (exp_kind.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected pulses left, required 0", exp_kind.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debounce_tick.md
# debounce_tick

Synchronizes and debounces one asynchronous, bouncy input such as a push-button or switch. It uses a periodic single-cycle `tick` enable, normally the terminal-count tick of the free-running prescaler counter, as its sample strobe. It produces a clean registered level plus single-cycle rise and fall pulses for downstream control logic. It sits directly downstream of the prescaler, consuming its `tick`, and upstream of any logic that reacts to button events.

## Interface
- `STABLE_TICKS`, default 4: consecutive `tick` samples the synchronized input must hold before the output level changes. Legal range is 1..255.
- `clk` input 1: system clock; all flops update on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on `clk`.
- `tick` input 1: sample enable from the prescaler; high for one `clk` cycle per period.
- `btn_in` input 1: raw asynchronous input.
- `level` output 1: debounced state of `btn_in`.
- `rise` output 1: one-cycle pulse when `level` goes 0->1.
- `fall` output 1: one-cycle pulse when `level` goes 1->0.

## Operation
- **Synchronizer.** Two flops, `sync1` then `s`, both reset to 0. Only `s` feeds the FSM.
- **Counter.** The stability counter is `$clog2(STABLE_TICKS+1)` bits wide, reset to 0, and never wraps.
- **FSM states.** LOW, WAIT_HIGH, HIGH, WAIT_LOW. Reset state is LOW.
- **LOW:**
  - `s`=1: go to WAIT_HIGH, count<=0.
  - Otherwise stay. `tick` is ignored.
- **WAIT_HIGH:**
  - `s`=0: go to LOW, count<=0. This applies even if `tick`=1 in the same cycle; the bounce wins.
  - `s`=1 and `tick`=1: count<=count+1. If count+1==STABLE_TICKS, go to HIGH with `level`<=1, `rise`<=1, count<=0.
  - `s`=1 and `tick`=0: hold.
- **HIGH.** Mirror of LOW: `s`=0 goes to WAIT_LOW with count<=0.
- **WAIT_LOW.** Mirror of WAIT_HIGH:
  - `s`=1 returns to HIGH with count<=0.
  - On the final tick, go to LOW with `level`<=0, `fall`<=1.
- **Pulse rules.** `rise` and `fall` are registered. Each is cleared on every edge where it is not being set, so it is high for exactly one cycle. The two are never high together.
- **Level.** `level` is registered and equals 1 exactly when state is HIGH or WAIT_LOW.
- **Reset values.** `level`=0, `rise`=0, `fall`=0, state LOW, count 0, `sync1`/`s`=0.
- **Reset mid-operation.** Any state returns to LOW immediately with no pulse. After release, if `btn_in` is held high, the full debounce runs again and `rise` fires normally.

## Timing
- **Synchronizer delay.** A `btn_in` change set up before edge E reaches `s` at edge E+1. The FSM leaves LOW/HIGH at edge E+2.
- **Tick counting.** Ticks are counted only in cycles where the state is already WAIT_*. A `tick` coincident with the LOW->WAIT_HIGH transition edge is not counted.
- **Latency with `tick` held at 1.** `level` changes and the pulse asserts at edge E+2+STABLE_TICKS. With STABLE_TICKS=4 that is edge E+6, i.e. the 7th edge counting E as the first. The pulse deasserts at the next edge.
- **Latency with periodic ticks.** `level` changes on the edge that samples the STABLE_TICKS-th tick after entry to WAIT_*. Worst-case latency is 2 + STABLE_TICKS×period cycles.
- **Throughput.** At most one `rise` or `fall` per STABLE_TICKS ticks.
- **STABLE_TICKS=1.** The first tick in WAIT_* completes the transition.

## Test plan
Bench uses STABLE_TICKS=4.

1. **Reset.** Drive `rst`=0 mid-cycle with `btn_in`=1 and `tick`=1 → `level`/`rise`/`fall` read 0 before the next `clk` edge. Hold for 3 cycles → outputs remain 0.
2. **Clean press, `tick`=1.** Raise `btn_in` before edge 1 → `level`=1 and `rise`=1 after edge 7. After edge 8, `rise`=0 and `level`=1. `fall` stays 0 throughout.
3. **Bounce rejection.** Pulse `btn_in` high for 3 cycles, then low, with `tick`=1 → `level` stays 0 and `rise` never asserts. Repeat with glitches every 2 cycles for 40 cycles → no pulse.
4. **Sparse tick.** Tick once every 16 cycles (4-bit prescaler) with `btn_in` held high → `rise` on the edge sampling the 4th tick after entering WAIT_HIGH. Count must not advance between ticks.
5. **Release and final-tick collision.** From HIGH, drop `btn_in` → `fall` for one cycle and `level`=0 after 4 ticks. Separately, make `s` return to 1 in the same cycle as the 4th tick → no `fall`, and `level` stays 1.
6. **Reset mid-WAIT.** Assert `rst` after 2 counted ticks in WAIT_HIGH, release with `btn_in` still 1 → no pulse during reset. `rise` then fires after a full 4-tick debounce, at edge 7 after release with `tick`=1.
